ibex_rf_write_arbiter: RTL and testbench
========================================

IBEX_RF_WRITE_ARBITER -- requirements
Module: ibex_rf_write_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, register data width.
REQ-002 SHALL have parameter FifoDepth, default 2, number of EX write-buffer entries (range 1..4).
REQ-003 SHALL have port clk_int  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ex_valid_i  input  1, ex_waddr_i  input  5, ex_wdata_i  input  DataWidth  EX result write request.
REQ-006 SHALL have port ex_ready_o  output  1  EX request accepted this cycle when ex_valid_i=1.
REQ-007 SHALL have ports lsu_valid_i  input  1, lsu_waddr_i  input  5, lsu_wdata_i  input  DataWidth  load write; always accepted, no ready.
REQ-008 SHALL have ports rf_we_o  output  1, rf_waddr_o  output  5, rf_wdata_o  output  DataWidth  register-file write port.
REQ-009 SHALL have ports raddr_a_i, raddr_b_i  input  5  register-file read addresses under decode.
REQ-010 SHALL have ports fwd_a_valid_o, fwd_b_valid_o  output  1, fwd_a_data_o, fwd_b_data_o  output  DataWidth  forwarded pending data.
REQ-011 SHALL have port hazard_o  output  1  a read address matches a pending, unforwardable write.

Function
REQ-012 Per-cycle source select priority: lsu_valid_i, then FIFO head (if count>0), then EX input direct (bypass, only when FIFO empty and ex_valid_i=1).
REQ-013 ex_ready_o SHALL equal (count < FifoDepth), combinational from state only.
REQ-014 An accepted EX request not selected that cycle SHALL be enqueued at FIFO tail; head dequeued only when selected.
REQ-015 Simultaneous enqueue and dequeue SHALL keep count unchanged; count never exceeds FifoDepth or wraps below 0.
REQ-016 Selected write SHALL appear on rf_we_o/rf_waddr_o/rf_wdata_o registered, exactly 1 cycle after selection; rf_we_o=0 in cycles with no selection.
REQ-017 Writes to address 0 SHALL be accepted/dequeued normally but drive rf_we_o=0.
REQ-018 LSU write SHALL be treated as younger than every buffered FIFO entry: buffered entries whose address equals lsu_waddr_i SHALL be squashed (invalidated, dequeued without write when reaching head).
REQ-019 EX input in the same cycle as LSU write SHALL be treated as younger than that LSU write and be written after it.
REQ-020 Pending set = output stage (if rf_we_o) plus valid FIFO entries; age order youngest-first: FIFO tail ... FIFO head, output stage.
REQ-021 Read address 0 SHALL never match pending entries.

Reset
REQ-022 On rst_ni=0 (any time, including mid-transfer): count=0, all FIFO entries invalid, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0; ex_ready_o=1 while in reset and afterwards; buffered writes discarded.
REQ-023 fwd_*_valid_o=0 and hazard_o=0 while in reset.

Configuration
REQ-024 Macro IBEX_RF_WR_FWD_EN SHALL select forwarding.
REQ-025 With IBEX_RF_WR_FWD_EN defined: fwd_x_valid_o=1 and fwd_x_data_o=data of youngest pending entry matching raddr_x_i; hazard_o tied 0.
REQ-026 Without it: fwd_*_valid_o tied 0, fwd_*_data_o tied 0; hazard_o=1 when raddr_a_i or raddr_b_i matches any pending entry.

Verification
REQ-027 Reset, EX write x5=0xA5A5_0001, no LSU -> rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA5A5_0001 next cycle, count stays 0.
REQ-028 LSU x7=0x11 and EX x8=0x22 same cycle, then idle -> cycle+1 writes x7=0x11, cycle+2 writes x8=0x22.
REQ-029 LSU valid 3 consecutive cycles with EX valid every cycle (FifoDepth=2) -> ex_ready_o drops to 0 in cycle 3; EX writes emerge in order afterwards, none lost.
REQ-030 Buffer EX x9=0x1, then LSU x9=0x2 -> only x9=0x2 written; EX entry squashed, no write of 0x1.
REQ-031 EX x0=0xFFFF_FFFF -> ex_ready_o=1, rf_we_o stays 0; raddr_a_i=0 never forwards or raises hazard_o.
REQ-032 With x3 buffered (0x33) and raddr_b_i=3: with IBEX_RF_WR_FWD_EN fwd_b_valid_o=1, fwd_b_data_o=0x33; without, hazard_o=1; assert rst_ni=0 mid-buffer -> all outputs 0 next.

Source files
------------

// File: rtl/ibex_rf_write_arbiter.sv
// Register-file write arbiter: merges LSU load writes and EX results onto a
// single register-file write port. EX results that lose arbitration wait in a
// small in-order buffer. An LSU write squashes older buffered writes to the
// same register. Pending writes are either forwarded to the decode read ports
// or reported as a hazard.
// Build option: define IBEX_RF_WR_FWD_EN to forward pending data instead of
// raising hazard_o.
module ibex_rf_write_arbiter #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned FifoDepth = 2
) (
   input  logic                 clk_int,
   input  logic                 rst_ni,
   input  logic                 ex_valid_i,
   input  logic [4:0]           ex_waddr_i,
   input  logic [DataWidth-1:0] ex_wdata_i,
   output logic                 ex_ready_o,
   input  logic                 lsu_valid_i,
   input  logic [4:0]           lsu_waddr_i,
   input  logic [DataWidth-1:0] lsu_wdata_i,
   output logic                 rf_we_o,
   output logic [4:0]           rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   output logic                 fwd_a_valid_o,
   output logic                 fwd_b_valid_o,
   output logic [DataWidth-1:0] fwd_a_data_o,
   output logic [DataWidth-1:0] fwd_b_data_o,
   output logic                 hazard_o
);

   localparam int unsigned CntW  = $clog2(FifoDepth + 1);
   localparam int unsigned AddrW = 5;

`ifdef IBEX_RF_WR_FWD_EN
   localparam bit FwdEn = 1'b1;
`else
   localparam bit FwdEn = 1'b0;
`endif

   // Buffer entry 0 is the head (oldest); entries at and above count are invalid.
   logic [FifoDepth-1:0] ent_valid_q, ent_valid_d;
   logic [AddrW-1:0]     ent_addr_q [FifoDepth];
   logic [AddrW-1:0]     ent_addr_d [FifoDepth];
   logic [DataWidth-1:0] ent_data_q [FifoDepth];
   logic [DataWidth-1:0] ent_data_d [FifoDepth];
   logic [CntW-1:0]      count_q, count_d;

   logic                 rf_we_q, rf_we_d;
   logic [AddrW-1:0]     rf_waddr_q, rf_waddr_d;
   logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;

   logic                 sel_lsu, sel_head, sel_bypass, ex_acc, enq;
   logic [CntW-1:0]      wr_idx;

   logic                 hit_a, hit_b;
   logic [DataWidth-1:0] data_a, data_b;

   assign ex_ready_o = (count_q < CntW'(FifoDepth));

   // Source selection: LSU first, then buffer head, then EX bypass when empty.
   always_comb begin
      sel_lsu    = lsu_valid_i;
      sel_head   = !lsu_valid_i && (count_q != '0);
      sel_bypass = !lsu_valid_i && (count_q == '0) && ex_valid_i;
      ex_acc     = ex_valid_i && ex_ready_o;
      enq        = ex_acc && !sel_bypass;
      wr_idx     = count_q - CntW'(sel_head);
   end

   // Buffer next state: squash on LSU hit, shift on dequeue, then enqueue at tail.
   always_comb begin
      ent_valid_d = ent_valid_q;
      ent_addr_d  = ent_addr_q;
      ent_data_d  = ent_data_q;
      count_d     = count_q + CntW'(enq) - CntW'(sel_head);

      if (sel_lsu) begin
         for (int unsigned i = 0; i < FifoDepth; i++) begin
            if (ent_valid_q[i] && (ent_addr_q[i] == lsu_waddr_i)) begin
               ent_valid_d[i] = 1'b0;
            end
         end
      end

      if (sel_head) begin
         for (int unsigned i = 0; i + 1 < FifoDepth; i++) begin
            ent_valid_d[i] = ent_valid_d[i+1];
            ent_addr_d[i]  = ent_addr_d[i+1];
            ent_data_d[i]  = ent_data_d[i+1];
         end
         ent_valid_d[FifoDepth-1] = 1'b0;
      end

      if (enq) begin
         for (int unsigned i = 0; i < FifoDepth; i++) begin
            if (CntW'(i) == wr_idx) begin
               ent_valid_d[i] = 1'b1;
               ent_addr_d[i]  = ex_waddr_i;
               ent_data_d[i]  = ex_wdata_i;
            end
         end
      end
   end

   // Output stage next state; writes to x0 are consumed without a write enable.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (sel_lsu) begin
         rf_we_d    = (lsu_waddr_i != '0);
         rf_waddr_d = lsu_waddr_i;
         rf_wdata_d = lsu_wdata_i;
      end else if (sel_head) begin
         rf_we_d    = ent_valid_q[0] && (ent_addr_q[0] != '0);
         rf_waddr_d = ent_addr_q[0];
         rf_wdata_d = ent_data_q[0];
      end else if (sel_bypass) begin
         rf_we_d    = (ex_waddr_i != '0);
         rf_waddr_d = ex_waddr_i;
         rf_wdata_d = ex_wdata_i;
      end
   end

   // State registers.
   always_ff @(posedge clk_int or negedge rst_ni) begin
      if (!rst_ni) begin
         ent_valid_q <= '0;
         count_q     <= '0;
         rf_we_q     <= 1'b0;
         rf_waddr_q  <= '0;
         rf_wdata_q  <= '0;
         for (int unsigned i = 0; i < FifoDepth; i++) begin
            ent_addr_q[i] <= '0;
            ent_data_q[i] <= '0;
         end
      end else begin
         ent_valid_q <= ent_valid_d;
         ent_addr_q  <= ent_addr_d;
         ent_data_q  <= ent_data_d;
         count_q     <= count_d;
         rf_we_q     <= rf_we_d;
         rf_waddr_q  <= rf_waddr_d;
         rf_wdata_q  <= rf_wdata_d;
      end
   end

   // Youngest pending match per read port: output stage, then head up to tail.
   always_comb begin
      hit_a  = 1'b0;
      hit_b  = 1'b0;
      data_a = '0;
      data_b = '0;
      if (rf_we_q && (rf_waddr_q == raddr_a_i)) begin
         hit_a  = 1'b1;
         data_a = rf_wdata_q;
      end
      if (rf_we_q && (rf_waddr_q == raddr_b_i)) begin
         hit_b  = 1'b1;
         data_b = rf_wdata_q;
      end
      for (int unsigned i = 0; i < FifoDepth; i++) begin
         if (ent_valid_q[i] && (ent_addr_q[i] == raddr_a_i)) begin
            hit_a  = 1'b1;
            data_a = ent_data_q[i];
         end
         if (ent_valid_q[i] && (ent_addr_q[i] == raddr_b_i)) begin
            hit_b  = 1'b1;
            data_b = ent_data_q[i];
         end
      end
      if (raddr_a_i == '0) begin
         hit_a  = 1'b0;
         data_a = '0;
      end
      if (raddr_b_i == '0) begin
         hit_b  = 1'b0;
         data_b = '0;
      end
   end

   assign rf_we_o       = rf_we_q;
   assign rf_waddr_o    = rf_waddr_q;
   assign rf_wdata_o    = rf_wdata_q;
   assign fwd_a_valid_o = FwdEn && hit_a;
   assign fwd_b_valid_o = FwdEn && hit_b;
   assign fwd_a_data_o  = FwdEn ? data_a : '0;
   assign fwd_b_data_o  = FwdEn ? data_b : '0;
   assign hazard_o      = !FwdEn && (hit_a || hit_b);

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Bench for ibex_rf_write_arbiter: directed vector table, reset/forwarding
// sequence, and random traffic against a queue-based reference model.
module tb_ibex_rf_write_arbiter;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 2;

   logic          clk_int = 1'b0;
   logic          rst_ni;
   logic          ex_valid_i, lsu_valid_i;
   logic [4:0]    ex_waddr_i, lsu_waddr_i, raddr_a_i, raddr_b_i;
   logic [DW-1:0] ex_wdata_i, lsu_wdata_i;
   logic          ex_ready_o, rf_we_o, fwd_a_valid_o, fwd_b_valid_o, hazard_o;
   logic [4:0]    rf_waddr_o;
   logic [DW-1:0] rf_wdata_o, fwd_a_data_o, fwd_b_data_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_int = ~clk_int;

   ibex_rf_write_arbiter #(.DataWidth(DW), .FifoDepth(DEPTH)) dut (
      .clk_int      (clk_int),
      .rst_ni       (rst_ni),
      .ex_valid_i   (ex_valid_i),
      .ex_waddr_i   (ex_waddr_i),
      .ex_wdata_i   (ex_wdata_i),
      .ex_ready_o   (ex_ready_o),
      .lsu_valid_i  (lsu_valid_i),
      .lsu_waddr_i  (lsu_waddr_i),
      .lsu_wdata_i  (lsu_wdata_i),
      .rf_we_o      (rf_we_o),
      .rf_waddr_o   (rf_waddr_o),
      .rf_wdata_o   (rf_wdata_o),
      .raddr_a_i    (raddr_a_i),
      .raddr_b_i    (raddr_b_i),
      .fwd_a_valid_o(fwd_a_valid_o),
      .fwd_b_valid_o(fwd_b_valid_o),
      .fwd_a_data_o (fwd_a_data_o),
      .fwd_b_data_o (fwd_b_data_o),
      .hazard_o     (hazard_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                        input logic [4:0] ra, input logic [4:0] rb);
      lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
      ex_valid_i  = ev; ex_waddr_i  = ea; ex_wdata_i  = ed;
      raddr_a_i   = ra; raddr_b_i   = rb;
   endtask

   // Directed vectors: inputs for one cycle, ready during it, write port after the edge.
   typedef struct {
      logic        lv; logic [4:0] la; logic [31:0] ld;
      logic        ev; logic [4:0] ea; logic [31:0] ed;
      logic        rdy;
      logic        we; logic [4:0] wa; logic [31:0] wd;
   } vec_t;
   vec_t tbl[16];

   // Reference model: pending buffer as a queue (front = oldest) plus output stage.
   typedef struct { logic [4:0] a; logic [31:0] d; bit v; } ent_t;
   ent_t        mq[$];
   bit          m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;

   function automatic void lookup(input logic [4:0] r, output bit hit, output logic [31:0] d);
      hit = 0;
      d   = '0;
      if (r == 5'd0) return;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].v && mq[i].a == r) begin
            hit = 1;
            d   = mq[i].d;
            return;
         end
      end
      if (m_we && m_wa == r) begin
         hit = 1;
         d   = m_wd;
      end
   endfunction

   task automatic check_read_side(input string tag);
      bit hit_a, hit_b;
      logic [31:0] da, db;
      lookup(raddr_a_i, hit_a, da);
      lookup(raddr_b_i, hit_b, db);
`ifdef IBEX_RF_WR_FWD_EN
      chk({tag, "_fwd_a_valid"}, 32'(fwd_a_valid_o), 32'(hit_a));
      chk({tag, "_fwd_b_valid"}, 32'(fwd_b_valid_o), 32'(hit_b));
      if (hit_a) chk({tag, "_fwd_a_data"}, fwd_a_data_o, da);
      if (hit_b) chk({tag, "_fwd_b_data"}, fwd_b_data_o, db);
      chk({tag, "_hazard"}, 32'(hazard_o), 32'd0);
`else
      chk({tag, "_hazard"}, 32'(hazard_o), 32'(hit_a || hit_b));
      chk({tag, "_fwd_valid"}, 32'({fwd_a_valid_o, fwd_b_valid_o}), 32'd0);
`endif
   endtask

   task automatic model_step();
      bit rdy;
      ent_t h;
      rdy = (mq.size() < DEPTH);
      if (lsu_valid_i) begin
         foreach (mq[i]) if (mq[i].a == lsu_waddr_i) mq[i].v = 0;
         m_we = (lsu_waddr_i != 0); m_wa = lsu_waddr_i; m_wd = lsu_wdata_i;
         if (ex_valid_i && rdy) mq.push_back('{ex_waddr_i, ex_wdata_i, 1'b1});
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         m_we = h.v && (h.a != 0); m_wa = h.a; m_wd = h.d;
         if (ex_valid_i && rdy) mq.push_back('{ex_waddr_i, ex_wdata_i, 1'b1});
      end else if (ex_valid_i) begin
         m_we = (ex_waddr_i != 0); m_wa = ex_waddr_i; m_wd = ex_wdata_i;
      end else begin
         m_we = 0;
      end
   endtask

   initial begin
      tbl[0]  = '{0, 5'd0,  32'h0,    1, 5'd5,  32'hA5A5_0001, 1, 1, 5'd5,  32'hA5A5_0001};
      tbl[1]  = '{1, 5'd7,  32'h11,   1, 5'd8,  32'h22,        1, 1, 5'd7,  32'h11};
      tbl[2]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 1, 5'd8,  32'h22};
      tbl[3]  = '{1, 5'd1,  32'h1001, 1, 5'd10, 32'hE001,      1, 1, 5'd1,  32'h1001};
      tbl[4]  = '{1, 5'd2,  32'h1002, 1, 5'd11, 32'hE002,      1, 1, 5'd2,  32'h1002};
      tbl[5]  = '{1, 5'd3,  32'h1003, 1, 5'd12, 32'hE003,      0, 1, 5'd3,  32'h1003};
      tbl[6]  = '{0, 5'd0,  32'h0,    1, 5'd12, 32'hE003,      0, 1, 5'd10, 32'hE001};
      tbl[7]  = '{0, 5'd0,  32'h0,    1, 5'd12, 32'hE003,      1, 1, 5'd11, 32'hE002};
      tbl[8]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 1, 5'd12, 32'hE003};
      tbl[9]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 0, 5'd0,  32'h0};
      tbl[10] = '{1, 5'd4,  32'h44,   1, 5'd9,  32'h1,         1, 1, 5'd4,  32'h44};
      tbl[11] = '{1, 5'd9,  32'h2,    0, 5'd0,  32'h0,         1, 1, 5'd9,  32'h2};
      tbl[12] = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 0, 5'd0,  32'h0};
      tbl[13] = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 0, 5'd0,  32'h0};
      tbl[14] = '{0, 5'd0,  32'h0,    1, 5'd0,  32'hFFFF_FFFF, 1, 0, 5'd0,  32'h0};
      tbl[15] = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,         1, 0, 5'd0,  32'h0};

      // Reset state
      rst_ni = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      chk("rst_we",    32'(rf_we_o),    32'd0);
      chk("rst_waddr", 32'(rf_waddr_o), 32'd0);
      chk("rst_wdata", rf_wdata_o,      32'd0);
      chk("rst_ready", 32'(ex_ready_o), 32'd1);
      chk("rst_hazard", 32'(hazard_o),  32'd0);
      chk("rst_fwd",   32'({fwd_a_valid_o, fwd_b_valid_o}), 32'd0);
      @(negedge clk_int);
      rst_ni = 1'b1;
      @(posedge clk_int); #1;

      // Directed table
      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].lv, tbl[i].la, tbl[i].ld, tbl[i].ev, tbl[i].ea, tbl[i].ed, 5'd0, 5'd0);
         #4;
         chk($sformatf("vec%0d_ready", i),  32'(ex_ready_o), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d_hazard", i), 32'(hazard_o),   32'd0);
         chk($sformatf("vec%0d_fwd_a", i),  32'(fwd_a_valid_o), 32'd0);
         @(posedge clk_int); #1;
         chk($sformatf("vec%0d_we", i), 32'(rf_we_o), 32'(tbl[i].we));
         if (tbl[i].we) begin
            chk($sformatf("vec%0d_waddr", i), 32'(rf_waddr_o), 32'(tbl[i].wa));
            chk($sformatf("vec%0d_wdata", i), rf_wdata_o, tbl[i].wd);
         end
      end

      // Buffered x3 seen by read port b, then asynchronous reset mid-buffer
      drive(1, 5'd1, 32'h100, 1, 5'd3, 32'h33, 5'd0, 5'd0);
      @(posedge clk_int); #1;
      drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd3);
      #1;
`ifdef IBEX_RF_WR_FWD_EN
      chk("buf_fwd_b_valid", 32'(fwd_b_valid_o), 32'd1);
      chk("buf_fwd_b_data",  fwd_b_data_o,       32'h33);
      chk("buf_hazard",      32'(hazard_o),      32'd0);
`else
      chk("buf_hazard",      32'(hazard_o),      32'd1);
      chk("buf_fwd_b_valid", 32'(fwd_b_valid_o), 32'd0);
`endif
      rst_ni = 1'b0;
      #1;
      chk("midrst_we",     32'(rf_we_o),    32'd0);
      chk("midrst_waddr",  32'(rf_waddr_o), 32'd0);
      chk("midrst_wdata",  rf_wdata_o,      32'd0);
      chk("midrst_ready",  32'(ex_ready_o), 32'd1);
      chk("midrst_hazard", 32'(hazard_o),   32'd0);
      chk("midrst_fwd_b",  32'(fwd_b_valid_o), 32'd0);
      @(negedge clk_int);
      rst_ni = 1'b1;
      @(posedge clk_int); #1;
      chk("postrst_we",    32'(rf_we_o),    32'd0);
      chk("postrst_ready", 32'(ex_ready_o), 32'd1);

      // Random traffic against the reference model
      mq.delete();
      m_we = 0; m_wa = '0; m_wd = '0;
      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         #4;
         chk("rnd_ready", 32'(ex_ready_o), 32'(mq.size() < DEPTH));
         check_read_side("rnd");
         model_step();
         @(posedge clk_int); #1;
         chk("rnd_we", 32'(rf_we_o), 32'(m_we));
         if (m_we) begin
            chk("rnd_waddr", 32'(rf_waddr_o), 32'(m_wa));
            chk("rnd_wdata", rf_wdata_o, m_wd);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
